// File: rtl/m_lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: memOp codes, exception
// codes and FSM state encodings.
package m_lsu_pkg;

  localparam logic [3:0] memOp_nope = 4'd0;
  localparam logic [3:0] memOp_w    = 4'd1;
  localparam logic [3:0] memOp_h    = 4'd2;
  localparam logic [3:0] memOp_b    = 4'd3;
  localparam logic [3:0] memOp_hu   = 4'd4;
  localparam logic [3:0] memOp_bu   = 4'd5;

  localparam logic [4:0] exc_AdEL = 5'd4;
  localparam logic [4:0] exc_AdES = 5'd5;
  localparam logic [4:0] exc_DBE  = 5'd7;

  typedef enum logic [1:0] {
    lsu_IDLE = 2'd0,
    lsu_BUS  = 2'd1,
    lsu_DONE = 2'd2
  } lsu_state_t;

  // Codes above bu are not memory operations and behave like nope.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= memOp_w) && (op <= memOp_bu);
  endfunction

endpackage

// File: rtl/m_lsu_if.sv
// Word bus between the load/store unit (master) and data memory (slave).
// Handshake: master raises bus_req with all fields stable and holds them until
// the single-cycle bus_ack; bus_rdata is valid only in the bus_ack cycle.
interface m_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/m_lsu_align.sv
// Combinational datapath of the load/store unit: alignment check, byte
// enables, write-lane replication, and load byte/half extraction with extension.
module m_lsu_align
  import m_lsu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_word,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_lanes,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // hu/bu share h/b enables and lanes, which also covers stores coded as hu/bu.
  always_comb begin
    o_misalign = 1'b0;
    o_be       = 4'b1111;
    o_lanes    = i_wdata;
    case (i_op)
      memOp_w: o_misalign = (i_addr_lo != 2'b00);
      memOp_h, memOp_hu: begin
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lanes    = {2{i_wdata[15:0]}};
      end
      memOp_b, memOp_bu: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_lanes = {4{i_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

  always_comb begin
    w_byte = i_ld_word[7:0];
    case (i_ld_addr_lo)
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      2'd3:    w_byte = i_ld_word[31:24];
      default: w_byte = i_ld_word[7:0];
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_op)
      memOp_h:  o_ld_data = {{16{w_half[15]}}, w_half};
      memOp_hu: o_ld_data = {16'h0000, w_half};
      memOp_b:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      memOp_bu: o_ld_data = {24'h000000, w_byte};
      default:  o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store initiator: accepts one memory op, runs it over the word
// bus with a timeout, and returns extended load data or an exception.
module m_lsu
  import m_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [3:0]  mem_op,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output lsu_state_t  dbg_state,
  m_lsu_if.master     bus
);

  localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [1:0]    r_addr_lo;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_bus_wdata;
  logic          r_done;
  logic [31:0]   r_rdata;
  logic          r_exc;
  logic [4:0]    r_exc_code;
  logic [31:0]   r_exc_pc;

  logic          w_access;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_lanes;
  logic [31:0]   w_ld_data;

  m_lsu_align u_align (
    .i_op         (mem_op),
    .i_addr_lo    (addr[1:0]),
    .i_wdata      (wdata),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_word    (bus.bus_rdata),
    .o_misalign   (w_misalign),
    .o_be         (w_be),
    .o_lanes      (w_lanes),
    .o_ld_data    (w_ld_data)
  );

  assign w_access = req_valid & is_mem_op(mem_op);
  assign stall    = (r_state == lsu_BUS) | ((r_state == lsu_IDLE) & w_access);

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign exc           = r_exc;
  assign exc_code      = r_exc_code;
  assign exc_pc        = r_exc_pc;
  assign dbg_state     = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= lsu_IDLE;
      r_cnt       <= '0;
      r_op        <= memOp_nope;
      r_addr_lo   <= 2'b00;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_rdata     <= 32'h0;
      r_exc       <= 1'b0;
      r_exc_code  <= 5'h0;
      r_exc_pc    <= 32'h0;
    end else begin
      case (r_state)
        lsu_IDLE: begin
          if (w_access) begin
            r_exc_pc  <= pc;
            r_op      <= mem_op;
            r_addr_lo <= addr[1:0];
            if (w_misalign) begin
              r_state    <= lsu_DONE;
              r_done     <= 1'b1;
              r_exc      <= 1'b1;
              r_exc_code <= mem_write ? exc_AdES : exc_AdEL;
              r_rdata    <= 32'h0;
            end else begin
              r_state     <= lsu_BUS;
              r_bus_req   <= 1'b1;
              r_bus_we    <= mem_write;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_lanes;
              r_cnt       <= '0;
            end
          end
        end
        lsu_BUS: begin
          // Ack wins over the timeout on the final counted cycle.
          if (bus.bus_ack) begin
            r_state    <= lsu_DONE;
            r_bus_req  <= 1'b0;
            r_done     <= 1'b1;
            r_exc      <= 1'b0;
            r_exc_code <= 5'h0;
            r_rdata    <= r_bus_we ? 32'h0 : w_ld_data;
          end else if (r_cnt == LAST) begin
            r_state    <= lsu_DONE;
            r_bus_req  <= 1'b0;
            r_done     <= 1'b1;
            r_exc      <= 1'b1;
            r_exc_code <= exc_DBE;
            r_rdata    <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        lsu_DONE: begin
          r_state <= lsu_IDLE;
          r_done  <= 1'b0;
          r_exc   <= 1'b0;
        end
        default: r_state <= lsu_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_lsu.sv
// Bench for m_lsu: directed scenarios plus randomized accesses checked against
// a behavioural model of the access rules.
module tb_m_lsu;
  import m_lsu_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [3:0]  mem_op;
  logic        mem_write;
  logic [31:0] addr, wdata, pc;
  logic        stall, done, exc;
  logic [31:0] rdata, exc_pc;
  logic [4:0]  exc_code;
  lsu_state_t  dbg_state;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  m_lsu_if bus();

  m_lsu #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .mem_op(mem_op),
    .mem_write(mem_write), .addr(addr), .wdata(wdata), .pc(pc),
    .stall(stall), .done(done), .rdata(rdata), .exc(exc), .exc_code(exc_code),
    .exc_pc(exc_pc), .dbg_state(dbg_state), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int          done_cyc;
    int          req_cyc;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] exc_pc;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] bwdata;
    logic        stall_bad;
    logic        bus_bad;
  } obs_t;

  // Expected outcome of one access, straight from the access rules.
  function automatic obs_t model(input logic [3:0] op, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] pcv,
                                 input int waits, input logic [31:0] word);
    obs_t        e;
    logic [31:0] bsh, hsh;
    e = '{default:0};
    e.exc_pc = pcv;
    if ((op == memOp_w && a[1:0] != 2'b00) || ((op == memOp_h || op == memOp_hu) && a[0])) begin
      e.done_cyc = 1; e.exc = 1'b1; e.code = we ? 5'd5 : 5'd4;
      return e;
    end
    e.baddr = a & ~32'h3;
    e.we    = we;
    if (op == memOp_w) begin
      e.be = 4'hF; e.bwdata = wd;
    end else if (op == memOp_h || op == memOp_hu) begin
      e.be = a[1] ? 4'hC : 4'h3; e.bwdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e.be = 4'(1 << a[1:0]); e.bwdata = (wd & 32'hFF) * 32'h0101_0101;
    end
    if (waits >= T) begin
      e.req_cyc = T; e.done_cyc = T + 1; e.exc = 1'b1; e.code = 5'd7;
      return e;
    end
    e.req_cyc  = waits + 1;
    e.done_cyc = waits + 2;
    bsh = word >> (8 * a[1:0]);
    hsh = word >> (16 * a[1]);
    if (!we) begin
      case (op)
        memOp_h:  e.rdata = {{16{hsh[15]}}, hsh[15:0]};
        memOp_hu: e.rdata = {16'h0, hsh[15:0]};
        memOp_b:  e.rdata = {{24{bsh[7]}}, bsh[7:0]};
        memOp_bu: e.rdata = {24'h0, bsh[7:0]};
        default:  e.rdata = word;
      endcase
    end
    return e;
  endfunction

  // Drives one access from its accept cycle, acts as the memory responder
  // (ack after `waits` BUS cycles), and returns when the FSM is back in IDLE.
  task automatic do_access(input logic [3:0] op, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] pcv,
                           input int waits, input logic [31:0] word, output obs_t o);
    int req_n;
    o = '{default:0};
    o.done_cyc = -1;
    req_valid = 1'b1; mem_op = op; mem_write = we; addr = a; wdata = wd; pc = pcv;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    if (stall !== 1'b1) o.stall_bad = 1'b1;
    req_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        o.done_cyc = c; o.rdata = rdata; o.exc = exc; o.code = exc_code; o.exc_pc = exc_pc;
        if (stall !== 1'b0) o.stall_bad = 1'b1;
        break;
      end
      if (stall !== 1'b1) o.stall_bad = 1'b1;
      if (bus.bus_req === 1'b1) begin
        if (req_n == 0) begin
          o.baddr = bus.bus_addr; o.be = bus.bus_be; o.we = bus.bus_we; o.bwdata = bus.bus_wdata;
        end else if (o.baddr !== bus.bus_addr || o.be !== bus.bus_be ||
                     o.we !== bus.bus_we || o.bwdata !== bus.bus_wdata) begin
          o.bus_bad = 1'b1;
        end
        bus.bus_ack   = (req_n == waits);
        bus.bus_rdata = (req_n == waits) ? word : $urandom;
        req_n++;
      end else begin
        bus.bus_ack = 1'b0;
      end
    end
    o.req_cyc = req_n;
    bus.bus_ack = 1'b0; req_valid = 1'b0; mem_op = memOp_nope;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (dbg_state !== lsu_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    n_checks++; if ({bus.bus_req, bus.bus_we, bus.bus_be, done, exc, exc_code} !== 13'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h exp 0", {bus.bus_req, bus.bus_we, bus.bus_be, done, exc, exc_code}); end
    n_checks++; if ({bus.bus_addr, bus.bus_wdata, exc_pc, rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h exp 0", {bus.bus_addr, bus.bus_wdata, exc_pc, rdata}); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall); end
  endtask

  task automatic test_sw_zero_wait;
    obs_t o;
    do_access(memOp_w, 1'b1, 32'h14, 32'h1234_5678, 32'h400, 0, 32'h0, o);
    n_checks++; if (o.done_cyc !== 2) begin n_fail++; $display("FAIL sw_done_cyc: got %0d exp 2", o.done_cyc); end
    n_checks++; if (o.baddr !== 32'h14) begin n_fail++; $display("FAIL sw_addr: got %h exp 14", o.baddr); end
    n_checks++; if (o.be !== 4'hF || o.we !== 1'b1) begin n_fail++; $display("FAIL sw_be_we: got %h/%b exp f/1", o.be, o.we); end
    n_checks++; if (o.bwdata !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_wdata: got %h exp 12345678", o.bwdata); end
    n_checks++; if (o.stall_bad !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got bad=%b exp 0", o.stall_bad); end
    n_checks++; if (o.rdata !== 32'h0 || o.exc !== 1'b0) begin n_fail++; $display("FAIL sw_result: got %h/%b exp 0/0", o.rdata, o.exc); end
  endtask

  task automatic test_lb_lbu;
    obs_t o;
    do_access(memOp_b, 1'b0, 32'h23, 32'h0, 32'h404, 2, 32'h80FF_0000, o);
    n_checks++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h exp ffffff80", o.rdata); end
    n_checks++; if (o.done_cyc !== 4) begin n_fail++; $display("FAIL lb_done_cyc: got %0d exp 4", o.done_cyc); end
    n_checks++; if (o.be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b exp 1000", o.be); end
    do_access(memOp_bu, 1'b0, 32'h23, 32'h0, 32'h408, 2, 32'h80FF_0000, o);
    n_checks++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h exp 00000080", o.rdata); end
    n_checks++; if (o.done_cyc !== 4) begin n_fail++; $display("FAIL lbu_done_cyc: got %0d exp 4", o.done_cyc); end
  endtask

  task automatic test_sh;
    obs_t o;
    do_access(memOp_h, 1'b1, 32'h6, 32'hAAAA_BEEF, 32'h40C, 1, 32'h0, o);
    n_checks++; if (o.be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b exp 1100", o.be); end
    n_checks++; if (o.bwdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h exp beefbeef", o.bwdata); end
    n_checks++; if (o.bus_bad !== 1'b0) begin n_fail++; $display("FAIL sh_bus_stable: got bad=%b exp 0", o.bus_bad); end
  endtask

  task automatic test_misaligned;
    obs_t o;
    do_access(memOp_w, 1'b0, 32'h2, 32'h0, 32'h0000_1234, 0, 32'h0, o);
    n_checks++; if (o.req_cyc !== 0) begin n_fail++; $display("FAIL lw_mis_req: got %0d exp 0", o.req_cyc); end
    n_checks++; if (o.done_cyc !== 1) begin n_fail++; $display("FAIL lw_mis_done_cyc: got %0d exp 1", o.done_cyc); end
    n_checks++; if (o.exc !== 1'b1 || o.code !== 5'd4) begin n_fail++; $display("FAIL lw_mis_exc: got %b/%0d exp 1/4", o.exc, o.code); end
    n_checks++; if (o.exc_pc !== 32'h0000_1234) begin n_fail++; $display("FAIL lw_mis_pc: got %h exp 00001234", o.exc_pc); end
    do_access(memOp_h, 1'b1, 32'h1, 32'h5555, 32'h0000_1238, 0, 32'h0, o);
    n_checks++; if (o.exc !== 1'b1 || o.code !== 5'd5) begin n_fail++; $display("FAIL sh_mis_exc: got %b/%0d exp 1/5", o.exc, o.code); end
    n_checks++; if (o.req_cyc !== 0) begin n_fail++; $display("FAIL sh_mis_req: got %0d exp 0", o.req_cyc); end
  endtask

  task automatic test_timeout;
    obs_t o;
    do_access(memOp_w, 1'b0, 32'h30, 32'h0, 32'h500, 1000, 32'hDEAD_BEEF, o);
    n_checks++; if (o.req_cyc !== T) begin n_fail++; $display("FAIL to_req_cyc: got %0d exp %0d", o.req_cyc, T); end
    n_checks++; if (o.done_cyc !== T + 1) begin n_fail++; $display("FAIL to_done_cyc: got %0d exp %0d", o.done_cyc, T + 1); end
    n_checks++; if (o.exc !== 1'b1 || o.code !== 5'd7) begin n_fail++; $display("FAIL to_exc: got %b/%0d exp 1/7", o.exc, o.code); end
    n_checks++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h exp 0", o.rdata); end
    do_access(memOp_w, 1'b0, 32'h34, 32'h0, 32'h504, T - 1, 32'h0BAD_CAFE, o);
    n_checks++; if (o.exc !== 1'b0 || o.rdata !== 32'h0BAD_CAFE) begin
      n_fail++; $display("FAIL ack_last_cycle: got %b/%h exp 0/0badcafe", o.exc, o.rdata); end
  endtask

  task automatic test_ack_outside;
    req_valid = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1;
    repeat (2) @(negedge clk);
    n_checks++; if (dbg_state !== lsu_IDLE || done !== 1'b0 || bus.bus_req !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: got state=%0d done=%b req=%b exp 0/0/0", dbg_state, done, bus.bus_req); end
    bus.bus_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    obs_t o;
    int   start;
    int   bad = 0;
    start = cyc;
    for (int i = 0; i < 3; i++) begin
      do_access(memOp_w, i[0], 32'h100 + 32'(4 * i), 32'h77, 32'h600, 0, 32'h1111_0000 + 32'(i), o);
      if (o.done_cyc != 2) bad++;
    end
    n_checks++; if (cyc - start !== 9) begin n_fail++; $display("FAIL b2b_cycles: got %0d exp 9", cyc - start); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_done_cyc: got %0d late exp 0", bad); end
  endtask

  task automatic test_reset_mid_bus;
    obs_t o;
    req_valid = 1'b1; mem_op = memOp_w; mem_write = 1'b0; addr = 32'h40; pc = 32'h700;
    bus.bus_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rst_bus_pre: got %b exp 1", bus.bus_req); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.bus_req !== 1'b0 || dbg_state !== lsu_IDLE) begin
      n_fail++; $display("FAIL rst_bus_drop: got req=%b state=%0d exp 0/0", bus.bus_req, dbg_state); end
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_access(memOp_w, 1'b0, 32'h40, 32'h0, 32'h704, 0, 32'hCAFE_F00D, o);
    n_checks++; if (o.rdata !== 32'hCAFE_F00D || o.done_cyc !== 2) begin
      n_fail++; $display("FAIL rst_after_lw: got %h/%0d exp cafef00d/2", o.rdata, o.done_cyc); end
  endtask

  task automatic test_random;
    obs_t        o, e;
    logic [3:0]  op;
    logic        we;
    logic [31:0] a, wd, pcv, word, exp_rd;
    int          waits;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 5)); we = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; pcv = $urandom; word = $urandom;
      waits = $urandom_range(0, T);
      e = model(op, we, a, wd, pcv, waits, word);
      exp_q.push_back(e.rdata);
      do_access(op, we, a, wd, pcv, waits, word, o);
      exp_rd = exp_q.pop_front();
      n_checks++; if (o.rdata !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h exp %h", i, o.rdata, exp_rd); end
      n_checks++; if (o.done_cyc !== e.done_cyc || o.req_cyc !== e.req_cyc) begin
        n_fail++; $display("FAIL rnd%0d_timing: got %0d/%0d exp %0d/%0d", i, o.done_cyc, o.req_cyc, e.done_cyc, e.req_cyc); end
      n_checks++; if (o.exc !== e.exc || o.code !== e.code || o.exc_pc !== e.exc_pc) begin
        n_fail++; $display("FAIL rnd%0d_exc: got %b/%0d/%h exp %b/%0d/%h", i, o.exc, o.code, o.exc_pc, e.exc, e.code, e.exc_pc); end
      n_checks++; if (o.stall_bad !== 1'b0 || o.bus_bad !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_stall_bus: got %b/%b exp 0/0", i, o.stall_bad, o.bus_bad); end
      if (e.req_cyc > 0) begin
        n_checks++; if (o.baddr !== e.baddr || o.be !== e.be || o.we !== e.we) begin
          n_fail++; $display("FAIL rnd%0d_bus: got %h/%b/%b exp %h/%b/%b", i, o.baddr, o.be, o.we, e.baddr, e.be, e.we); end
        if (we) begin
          n_checks++; if (o.bwdata !== e.bwdata) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h exp %h", i, o.bwdata, e.bwdata); end
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; mem_op = memOp_nope; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_sw_zero_wait;
    test_lb_lbu;
    test_sh;
    test_misaligned;
    test_timeout;
    test_ack_outside;
    test_back_to_back;
    test_reset_mid_bus;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
